// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, counter debounce, press/release
// pulses and optional hold-to-repeat step pulses, one independent lane per button.

module button_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_n,
  output logic btn_clean_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] D_TERM  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_TERM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_TERM = RW'(REPEAT_PERIOD - 1);

  logic          sync1, sync2;
  logic [DW-1:0] dcnt;
  logic          flip, press_now, rel_now;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_raw_n;
      sync2 <= sync1;
    end
  end

  // The state flips on the last of an unbroken run of differing samples.
  assign flip      = (sync2 != btn_clean_n) && (dcnt == D_TERM);
  assign press_now = flip && !sync2;
  assign rel_now   = flip &&  sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dcnt          <= '0;
      btn_clean_n   <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_now;
      release_pulse <= rel_now;
      if (sync2 == btn_clean_n) begin
        dcnt <= '0;
      end else if (dcnt == D_TERM) begin
        btn_clean_n <= sync2;
        dcnt        <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rep
      typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} rstate_t;

      rstate_t       state, state_nx;
      logic [RW-1:0] rcnt, rcnt_nx;
      logic          rep_fire, step_nx;

      always_ff @(posedge clk) begin
        if (!reset) begin
          state      <= IDLE;
          rcnt       <= '0;
          step_pulse <= 1'b0;
        end else begin
          state      <= state_nx;
          rcnt       <= rcnt_nx;
          step_pulse <= step_nx;
        end
      end

      always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        unique case (state)
          IDLE: begin
            if (press_now) begin
              state_nx = HOLD_DELAY;
              rcnt_nx  = '0;
            end
          end
          HOLD_DELAY: begin
            if (rel_now) begin
              state_nx = IDLE;
              rcnt_nx  = '0;
            end else if (rcnt == RD_TERM) begin
              state_nx = HOLD_REPEAT;
              rcnt_nx  = '0;
            end else begin
              rcnt_nx = rcnt + 1'b1;
            end
          end
          HOLD_REPEAT: begin
            if (rel_now) begin
              state_nx = IDLE;
              rcnt_nx  = '0;
            end else if (rcnt == RP_TERM) begin
              rcnt_nx = '0;
            end else begin
              rcnt_nx = rcnt + 1'b1;
            end
          end
          default: begin
            state_nx = IDLE;
            rcnt_nx  = '0;
          end
        endcase
      end

      // A release landing on a terminal count suppresses that repeat.
      always_comb begin
        rep_fire = !rel_now &&
                   (((state == HOLD_DELAY)  && (rcnt == RD_TERM)) ||
                    ((state == HOLD_REPEAT) && (rcnt == RP_TERM)));
        step_nx  = press_now || rep_fire;
      end
    end else begin : g_norep
      always_ff @(posedge clk) begin
        if (!reset) step_pulse <= 1'b0;
        else        step_pulse <= press_now;
      end
    end
  endgenerate

endmodule

module button_debouncer #(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn_raw_n,
  output logic [N_BUTTONS-1:0] btn_clean_n,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] step_pulse
);

  generate
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_lane
      button_debouncer_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_EN       (REPEAT_EN),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_lane (
        .clk           (clk),
        .reset         (reset),
        .btn_raw_n     (btn_raw_n[i]),
        .btn_clean_n   (btn_clean_n[i]),
        .press_pulse   (press_pulse[i]),
        .release_pulse (release_pulse[i]),
        .step_pulse    (step_pulse[i])
      );
    end
  endgenerate

endmodule
